// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES permutation tables, key schedules, S-boxes, state enum and permute helper
package des_pkg;

    // Tables list 1-based DES bit numbers (bit 1 = MSB); unused tail entries are 0.
    typedef int tbl_t [64];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam tbl_t ip_tbl = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam tbl_t fp_tbl = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam tbl_t e_tbl = '{
        32,  1,  2,  3,  4,  5,  4,  5,   6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17,  16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27,  28, 29, 28, 29, 30, 31, 32,  1,
         0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  0,  0,  0,  0,  0,  0
    };

    localparam tbl_t p_tbl = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25,
         0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  0,  0,  0,  0,  0,  0,
         0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  0,  0,  0,  0,  0,  0
    };

    localparam tbl_t pc1_tbl = '{
        57, 49, 41, 33, 25, 17,  9,  1,  58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19,  11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7,  62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21,  13,  5, 28, 20, 12,  4,
         0,  0,  0,  0,  0,  0,  0,  0
    };

    localparam tbl_t pc2_tbl = '{
        14, 17, 11, 24,  1,  5,  3, 28,  15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2,  41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56,  34, 53, 46, 42, 50, 36, 29, 32,
         0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  0,  0,  0,  0,  0,  0
    };

    localparam int shift_dec [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int shift_enc [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // s1..s8, each indexed by {row[1:0], col[3:0]}
    localparam int sbox_tbl [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
    };

    // Output is right-aligned: first table entry lands in bit n_out-1.
    function automatic logic [63:0] permute(input tbl_t tbl, input logic [63:0] din,
                                            input int n_in, input int n_out);
        logic [63:0] res;
        res = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < n_out) res = {res[62:0], din[6'(n_in - tbl[i])]};
        end
        return res;
    endfunction

    // Six input bits {b5..b0}: row = {b5,b0}, column = b4:b1.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
        return 4'(sbox_tbl[box][{b[5], b[0], b[4:1]}]);
    endfunction

endpackage

// File: rtl/des_decrypt_core_f_function.sv
// rtl/des_decrypt_core_f_function.sv - combinational DES f(R, subkey): E, key mix, s1..s8, P
module des_f_function
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] subkey,
    output logic [31:0] f
);

    logic [47:0] x;
    logic [31:0] s_out;

    assign x = 48'(permute(e_tbl, 64'(r), 32, 48)) ^ subkey;

    for (genvar g = 0; g < 8; g++) begin : g_sbox
        assign s_out[31-4*g -: 4] = sbox_lookup(3'(g), x[47-6*g -: 6]);
    end

    assign f = 32'(permute(p_tbl, 64'(s_out), 32, 32));

endmodule

// File: rtl/des_decrypt_core.sv
// rtl/des_decrypt_core.sv - iterative DES decrypt core; DES_ENCRYPT_EN adds a mode port for encryption
module des_decrypt_core
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] cipher_in,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plain_out,
`ifdef DES_ENCRYPT_EN
    input  logic        mode,
`endif
    output logic        busy
);

    localparam int RPC = ROUNDS_PER_CYCLE;

    if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    function automatic logic [27:0] rotr28(input logic [27:0] v, input int n);
        return (n == 2) ? {v[1:0], v[27:2]} : (n == 1) ? {v[0], v[27:1]} : v;
    endfunction

`ifdef DES_ENCRYPT_EN
    function automatic logic [27:0] rotl28(input logic [27:0] v, input int n);
        return (n == 2) ? {v[25:0], v[27:26]} : (n == 1) ? {v[26:0], v[27]} : v;
    endfunction

    logic mode_q;
`endif

    state_t      state_q, state_d;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [4:0]  rnd_q;
    logic        accept, finish, release_out, last_round;

    logic [31:0] l_ch [RPC+1];
    logic [31:0] r_ch [RPC+1];
    logic [27:0] c_ch [RPC+1];
    logic [27:0] d_ch [RPC+1];

    assign l_ch[0] = l_q;
    assign r_ch[0] = r_q;
    assign c_ch[0] = c_q;
    assign d_ch[0] = d_q;

    // Unrolled round chain: each stage rotates C/D, derives its subkey and runs one Feistel round.
    for (genvar g = 0; g < RPC; g++) begin : g_round
        logic [3:0]  idx;
        logic [27:0] c_rot, d_rot;
        logic [47:0] subkey;
        logic [31:0] f_out;

        assign idx = rnd_q[3:0] + 4'(g);
`ifdef DES_ENCRYPT_EN
        assign c_rot = mode_q ? rotl28(c_ch[g], shift_enc[idx]) : rotr28(c_ch[g], shift_dec[idx]);
        assign d_rot = mode_q ? rotl28(d_ch[g], shift_enc[idx]) : rotr28(d_ch[g], shift_dec[idx]);
`else
        assign c_rot = rotr28(c_ch[g], shift_dec[idx]);
        assign d_rot = rotr28(d_ch[g], shift_dec[idx]);
`endif
        assign subkey = 48'(permute(pc2_tbl, {8'd0, c_rot, d_rot}, 56, 48));

        des_f_function u_f (
            .r      (r_ch[g]),
            .subkey (subkey),
            .f      (f_out)
        );

        assign c_ch[g+1] = c_rot;
        assign d_ch[g+1] = d_rot;
        assign l_ch[g+1] = r_ch[g];
        assign r_ch[g+1] = l_ch[g] ^ f_out;
    end

    assign last_round = (rnd_q + 5'(RPC)) == 5'd16;
    assign in_ready   = rst_n && (state_q == IDLE);
    assign busy       = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        finish      = 1'b0;
        release_out = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                accept  = 1'b1;
                state_d = ROUND;
            end
            ROUND: if (last_round) begin
                finish  = 1'b1;
                state_d = DONE;
            end
            DONE: if (out_ready) begin
                release_out = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accept, advance the round chain, capture and hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            rnd_q     <= '0;
            plain_out <= '0;
            out_valid <= 1'b0;
`ifdef DES_ENCRYPT_EN
            mode_q    <= 1'b0;
`endif
        end else if (accept) begin
            {l_q, r_q} <= permute(ip_tbl, cipher_in, 64, 64);
            {c_q, d_q} <= 56'(permute(pc1_tbl, key, 64, 56));
            rnd_q      <= '0;
`ifdef DES_ENCRYPT_EN
            mode_q     <= mode;
`endif
        end else if (state_q == ROUND) begin
            l_q   <= l_ch[RPC];
            r_q   <= r_ch[RPC];
            c_q   <= c_ch[RPC];
            d_q   <= d_ch[RPC];
            rnd_q <= rnd_q + 5'(RPC);
            if (finish) begin
                plain_out <= permute(fp_tbl, {r_ch[RPC], l_ch[RPC]}, 64, 64);
                out_valid <= 1'b1;
            end
        end else if (release_out) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_des_decrypt_core.sv
// tb/tb_des_decrypt_core.sv - scoreboard bench over ROUNDS_PER_CYCLE = 1, 2, 4 with a DES reference model
module tb_des_decrypt_core;
    import des_pkg::*;

    localparam logic [63:0] KAT1_K = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT1_C = 64'h85E813540F0AB405;
    localparam logic [63:0] KAT1_P = 64'h0123456789ABCDEF;
    localparam logic [63:0] KAT2_K = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KAT2_C = 64'h0000000000000000;
    localparam logic [63:0] KAT2_P = 64'h8787878787878787;
    localparam int LS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] cipher_in = '0;
    logic [63:0] key = '0;
`ifdef DES_ENCRYPT_EN
    logic        mode = 1'b0;
`endif
    logic [2:0]  in_ready, out_valid, busy;
    logic [63:0] plain_out [3];

    int          passed = 0;
    int          total = 0;
    longint      cyc = 0;
    longint      acc_cyc = 0;
    logic [63:0] exp_q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h required %h", name, act, want);
    endtask

    // Reference DES on 1-based bit numbering; encrypt schedule built forward by left shifts.
    function automatic logic [63:0] ref_perm(input logic [63:0] v, input int w_in, input int w_out, input tbl_t t);
        logic [63:0] o = '0;
        for (int i = 0; i < w_out; i++)
            o |= ((v >> (w_in - t[i])) & 64'd1) << (w_out - 1 - i);
        return o;
    endfunction

    function automatic logic [63:0] ref_des(input logic [63:0] blk, input logic [63:0] k, input bit enc);
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [47:0] x;
        logic [31:0] l, r, f, t;
        logic [63:0] v;
        logic [5:0]  six;
        int          row, col;
        v = ref_perm(k, 64, 56, pc1_tbl);
        c = v[55:28];
        d = v[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < LS[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            v = ref_perm({8'd0, c, d}, 56, 48, pc2_tbl);
            ks[i] = v[47:0];
        end
        v = ref_perm(blk, 64, 64, ip_tbl);
        l = v[63:32];
        r = v[31:0];
        for (int i = 0; i < 16; i++) begin
            v = ref_perm({32'd0, r}, 32, 48, e_tbl);
            x = v[47:0] ^ ks[enc ? i : 15 - i];
            f = '0;
            for (int b = 0; b < 8; b++) begin
                six = x[47 - 6*b -: 6];
                row = 2 * int'(six[5]) + int'(six[0]);
                col = int'(six[4:1]);
                f = (f << 4) | 32'(sbox_tbl[b][row*16 + col]);
            end
            v = ref_perm({32'd0, f}, 32, 32, p_tbl);
            t = r;
            r = l ^ v[31:0];
            l = t;
        end
        return ref_perm({r, l}, 64, 64, fp_tbl);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic prev_v = 1'b0;

        des_decrypt_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .cipher_in (cipher_in),
            .key       (key),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .plain_out (plain_out[g]),
`ifdef DES_ENCRYPT_EN
            .mode      (mode),
`endif
            .busy      (busy[g])
        );

        // Monitor: latency on each rise of out_valid, result compare on each transfer.
        always @(negedge clk) begin
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid[g] && !prev_v)
                    chk($sformatf("latency_rpc%0d", 1 << g), 64'(cyc - acc_cyc), 64'(16 >> g));
                if (out_valid[g] && out_ready) begin
                    if (exp_q[g].size() == 0) begin
                        total++;
                        $display("FAIL unexpected_out_rpc%0d: got %h required no transfer", 1 << g, plain_out[g]);
                    end else begin
                        chk($sformatf("result_rpc%0d", 1 << g), plain_out[g], exp_q[g].pop_front());
                    end
                end
                prev_v = out_valid[g];
            end
        end
    end

    function automatic bit queues_empty();
        return exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0;
    endfunction

    task automatic send(input logic [63:0] c, input logic [63:0] k, input logic [63:0] want);
        int t = 0;
        while (in_ready != 3'b111 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("accept_ready", 64'(in_ready), 64'(3'b111));
        for (int g = 0; g < 3; g++) exp_q[g].push_back(want);
        cipher_in = c;
        key       = k;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit toggle);
        int t = 0;
        while (!(in_ready == 3'b111 && queues_empty()) && t < 100) begin
            @(posedge clk); #1;
            t++;
            if (toggle) begin
                key       = {$urandom, $urandom};
                cipher_in = {$urandom, $urandom};
            end
        end
        chk("idle_within_100", 64'(t < 100), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] k, p;
        int          t;

        // Reset state
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        for (int g = 0; g < 3; g++) chk("rst_plain_out", plain_out[g], 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(3'b111));
        out_ready = 1'b1;

        // Known answers
        send(KAT1_C, KAT1_K, KAT1_P);
        wait_idle(1'b0);
        send(KAT2_C, KAT2_K, KAT2_P);
        wait_idle(1'b0);

        // Random blocks: encrypt in the model, expect the plaintext back
        for (int i = 0; i < 8; i++) begin
            k = {$urandom, $urandom};
            p = {$urandom, $urandom};
            send(ref_des(p, k, 1'b1), k, p);
            wait_idle(1'b0);
        end

        // Backpressure
        out_ready = 1'b0;
        send(KAT1_C, KAT1_K, KAT1_P);
        t = 0;
        while (out_valid != 3'b111 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("bp_all_valid", 64'(out_valid), 64'(3'b111));
        for (int i = 0; i < 10; i++) begin
            in_valid  = i[0];
            cipher_in = {$urandom, $urandom};
            key       = {$urandom, $urandom};
            @(posedge clk); #1;
            for (int g = 0; g < 3; g++) chk("bp_hold", plain_out[g], KAT1_P);
            chk("bp_busy", 64'(busy), 64'(3'b111));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'(3'b111));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'(3'b111));
        chk("bp_release_busy", 64'(busy), 64'd0);

        // Input isolation
        send(KAT1_C, KAT1_K, KAT1_P);
        wait_idle(1'b1);

        // Reset during round 7
        send(KAT1_C, KAT1_K, KAT1_P);
        repeat (6) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) exp_q[g].delete();
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        for (int g = 0; g < 3; g++) chk("midrst_plain_out", plain_out[g], 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("midrst_release_in_ready", 64'(in_ready), 64'(3'b111));
        send(KAT1_C, KAT1_K, KAT1_P);
        wait_idle(1'b0);

`ifdef DES_ENCRYPT_EN
        mode = 1'b1;
        send(KAT1_P, KAT1_K, KAT1_C);
        wait_idle(1'b0);
        mode = 1'b0;
        send(KAT1_C, KAT1_K, KAT1_P);
        wait_idle(1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", 64'(queues_empty()), 64'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
